fb_flush_arbiter: RTL and testbench
===================================

FB_FLUSH_ARBITER -- requirements
Module: fb_flush_arbiter

Interface
REQ-001 The block SHALL have parameter FRAME_PIXELS, default 76800, giving the number of pixels per frame (320x240).
REQ-002 The block SHALL have parameter SD_BASE, default 26'h0000000, giving the SDRAM byte address of pixel 0.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port bl_write  input  1  blender pixel write request.
REQ-006 The block SHALL have port bl_read  input  1  blender pixel read request.
REQ-007 The block SHALL have port bl_addr  input  17  blender pixel number.
REQ-008 The block SHALL have port bl_wdata  input  24  blender pixel {R,G,B}.
REQ-009 The block SHALL have port bl_rdata  output  24  M9 read data, passed through combinationally to the blender.
REQ-010 The block SHALL have port bl_grant  output  1  high when blender accesses are honoured.
REQ-011 The block SHALL have port frame_ready  input  1  single-cycle pulse; the frame is complete and flush starts.
REQ-012 The block SHALL have port m9_we, m9_waddr[16:0], m9_wdata[23:0], m9_raddr[16:0]  outputs  frame-buffer RAM control and write data.
REQ-013 The block SHALL have port m9_rdata  input  24  RAM read data, valid one cycle after m9_raddr is presented.
REQ-014 The block SHALL have port sd_write, sd_address[25:0], sd_wdata[31:0]  outputs  Avalon-MM master write.
REQ-015 The block SHALL have port sd_waitrequest  input  1  the slave stalls the current write while high.
REQ-016 The block SHALL have port flush_done  output  1  one-cycle pulse when the last pixel is accepted by SDRAM.
REQ-017 The block SHALL have port busy  output  1  high in every state except BLEND.

Function
REQ-018 The FSM SHALL have states BLEND, FL_ADDR, FL_DATA, FL_WRITE and DONE.
REQ-019 In BLEND:
- bl_grant = 1.
- m9_we = bl_write, m9_waddr = bl_addr, m9_wdata = bl_wdata, m9_raddr = bl_addr.
- Reads and writes are serviced in the same cycle.
REQ-020 BLEND SHALL go to FL_ADDR on frame_ready = 1; a bl_write in the same cycle is still performed.
REQ-021 In all states other than BLEND:
- bl_grant = 0 and m9_we = 0.
- Blender requests are dropped without side effect.
- frame_ready is ignored.
REQ-022 FL_ADDR SHALL drive m9_raddr = pix_cnt (17-bit counter, 0 on entry from BLEND) and go to FL_DATA.
REQ-023 FL_DATA SHALL latch m9_rdata into a 24-bit hold register and go to FL_WRITE.
REQ-024 FL_WRITE SHALL drive:
- sd_write = 1;
- sd_wdata = {8'h00, hold};
- sd_address = SD_BASE + 4*pix_cnt, computed modulo 2^26.
REQ-025 sd_write, sd_address and sd_wdata SHALL stay stable while sd_waitrequest = 1.
REQ-026 A write SHALL be accepted in the cycle where sd_write = 1 and sd_waitrequest = 0.
REQ-027 On acceptance:
- If pix_cnt = FRAME_PIXELS-1, go to DONE.
- Otherwise increment pix_cnt and go to FL_ADDR.
REQ-028 DONE SHALL assert flush_done for exactly one cycle, clear pix_cnt and return to BLEND.
REQ-029 sd_write SHALL be 0 in every state except FL_WRITE.
REQ-030 Back-to-back throughput with sd_waitrequest = 0 SHALL be one pixel per 3 cycles.
REQ-031 A full frame SHALL therefore take 3*FRAME_PIXELS+1 cycles from the frame_ready cycle to the flush_done cycle.
REQ-032 pix_cnt SHALL never exceed FRAME_PIXELS-1; no wrap is possible within a flush.

Reset
REQ-033 Asserting n_rst low SHALL immediately force:
- state = BLEND;
- pix_cnt = 0 and hold = 0;
- sd_write = 0, m9_we = 0, flush_done = 0, busy = 0.
REQ-034 A reset asserted mid-flush SHALL abandon the flush; no flush_done is issued and the next frame_ready restarts at pixel 0.

Structure
REQ-035 The state enum fb_flush_state_t and the constants PIX_W = 17, SD_ADDR_W = 26 and PIXEL_W = 24 SHALL live in the shared package gpu_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the M9 RAM remains external.

Verification
REQ-037 Blend access: bl_write=1, bl_addr=5, bl_wdata=24'hFF8040 -> m9_we=1, m9_waddr=5, m9_wdata=24'hFF8040 in the same cycle; bl_read=1, bl_addr=5 -> bl_rdata=24'hFF8040 next cycle.
REQ-038 Small flush: FRAME_PIXELS=4, SD_BASE=26'h100, frame_ready, no waitrequest ->
- sd_address 0x100/0x104/0x108/0x10C with sd_wdata {8'h00, RAM[n]};
- flush_done pulses at cycle 13;
- busy falls the cycle after.
REQ-039 Stall: sd_waitrequest held high for 5 cycles during pixel 2 -> sd_write, sd_address and sd_wdata are unchanged for those 5 cycles; RAM[2] is written to SDRAM exactly once.
REQ-040 Blocking during flush: bl_write=1 and a second frame_ready during the flush -> m9_we stays 0, bl_grant=0, and exactly one flush completes.
REQ-041 Reset in flight: n_rst low while in FL_WRITE for pixel 1 -> sd_write drops to 0 asynchronously, state = BLEND, no flush_done; a new frame_ready restarts at sd_address = SD_BASE.

Source files
------------

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared GPU types and widths for the frame-buffer flush path
//
// Purpose: state encoding of the flush arbiter, pixel/address widths and the
// pixel-number to SDRAM byte-address mapping.
// Ports: none (package).
package gpu_pkg;

  localparam int PIX_W     = 17;
  localparam int SD_ADDR_W = 26;
  localparam int PIXEL_W   = 24;

  typedef enum logic [2:0] {
    BLEND,
    FL_ADDR,
    FL_DATA,
    FL_WRITE,
    DONE
  } fb_flush_state_t;

  // One pixel occupies one 32-bit SDRAM word; the add wraps at 2^26.
  function automatic logic [SD_ADDR_W-1:0] pix_to_sd_addr(
    input logic [SD_ADDR_W-1:0] base,
    input logic [PIX_W-1:0]     pix
  );
    logic [SD_ADDR_W-1:0] ofs;
    ofs = {{(SD_ADDR_W-PIX_W-2){1'b0}}, pix, 2'b00};
    return base + ofs;
  endfunction

endpackage

// File: rtl/fb_flush_arbiter_if.sv
// rtl/fb_flush_arbiter_if.sv - Avalon-MM write bus between flush arbiter and SDRAM
//
// Purpose: groups the SDRAM master write signals.
// Ports (master view): sd_write, sd_address[25:0], sd_wdata[31:0] out;
//                      sd_waitrequest in.
interface fb_flush_arbiter_if;
  import gpu_pkg::*;

  logic                 sd_write;
  logic [SD_ADDR_W-1:0] sd_address;
  logic [31:0]          sd_wdata;
  logic                 sd_waitrequest;

  modport master (
    output sd_write,
    output sd_address,
    output sd_wdata,
    input  sd_waitrequest
  );

  modport slave (
    input  sd_write,
    input  sd_address,
    input  sd_wdata,
    output sd_waitrequest
  );

endinterface

// File: rtl/fb_flush_arbiter.sv
// rtl/fb_flush_arbiter.sv - frame-buffer arbiter: blender access, then flush to SDRAM
//
// Purpose: while blending, the blender owns the external M9 frame-buffer RAM.
// On frame_ready the arbiter takes the RAM and copies every pixel to SDRAM,
// one pixel per three cycles (address, data, write), then hands the RAM back.
// Ports:
//   clk, n_rst                          clock, asynchronous active-low reset
//   bl_write/bl_read/bl_addr/bl_wdata   blender requests
//   bl_rdata, bl_grant                  blender read data, access granted
//   frame_ready                         pulse: start flush
//   m9_we/m9_waddr/m9_wdata/m9_raddr    RAM control
//   m9_rdata                            RAM read data (one-cycle latency)
//   sd                                  SDRAM Avalon-MM write master
//   flush_done, busy                    flush complete pulse, not blending
module fb_flush_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned          FRAME_PIXELS = 76800,
  parameter logic [SD_ADDR_W-1:0] SD_BASE      = 26'h0000000
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               bl_write,
  input  logic               bl_read,
  input  logic [PIX_W-1:0]   bl_addr,
  input  logic [PIXEL_W-1:0] bl_wdata,
  output logic [PIXEL_W-1:0] bl_rdata,
  output logic               bl_grant,
  input  logic               frame_ready,
  output logic               m9_we,
  output logic [PIX_W-1:0]   m9_waddr,
  output logic [PIXEL_W-1:0] m9_wdata,
  output logic [PIX_W-1:0]   m9_raddr,
  input  logic [PIXEL_W-1:0] m9_rdata,
  fb_flush_arbiter_if.master sd,
  output logic               flush_done,
  output logic               busy
);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

  fb_flush_state_t    state_q, state_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PIXEL_W-1:0] hold_q, hold_d;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    hold_d    = hold_q;
    case (state_q)
      BLEND: begin
        if (frame_ready) begin
          state_d   = FL_ADDR;
          pix_cnt_d = '0;
        end
      end
      FL_ADDR: state_d = FL_DATA;
      FL_DATA: begin
        // RAM data for the address presented in FL_ADDR is valid now.
        hold_d  = m9_rdata;
        state_d = FL_WRITE;
      end
      FL_WRITE: begin
        if (!sd.sd_waitrequest) begin
          if (pix_cnt_q == LAST_PIX) begin
            state_d = DONE;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            state_d   = FL_ADDR;
          end
        end
      end
      DONE: begin
        pix_cnt_d = '0;
        state_d   = BLEND;
      end
      default: state_d = BLEND;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= BLEND;
      pix_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      hold_q    <= hold_d;
    end
  end

  // Outputs decode the state flops only, so reset clears them immediately
  // and the SDRAM write stays stable for as long as waitrequest holds it.
  assign bl_grant   = (state_q == BLEND);
  assign busy       = (state_q != BLEND);
  assign flush_done = (state_q == DONE);

  assign m9_we    = bl_grant & bl_write;
  assign m9_waddr = bl_addr;
  assign m9_wdata = bl_wdata;
  assign m9_raddr = bl_grant ? bl_addr : pix_cnt_q;
  assign bl_rdata = m9_rdata;

  assign sd.sd_write   = (state_q == FL_WRITE);
  assign sd.sd_address = pix_to_sd_addr(SD_BASE, pix_cnt_q);
  assign sd.sd_wdata   = {8'h00, hold_q};

endmodule

// File: tb/tb_fb_flush_arbiter.sv
// tb/tb_fb_flush_arbiter.sv - self-checking bench for fb_flush_arbiter
module tb_fb_flush_arbiter;

  localparam int          FP   = 4;
  localparam logic [25:0] BASE = 26'h100;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        bl_write = 1'b0;
  logic        bl_read = 1'b0;
  logic [16:0] bl_addr = '0;
  logic [23:0] bl_wdata = '0;
  logic [23:0] bl_rdata;
  logic        bl_grant;
  logic        frame_ready = 1'b0;
  logic        m9_we;
  logic [16:0] m9_waddr;
  logic [23:0] m9_wdata;
  logic [16:0] m9_raddr;
  logic [23:0] m9_rdata;
  logic        flush_done;
  logic        busy;

  fb_flush_arbiter_if sd_bus ();

  fb_flush_arbiter #(.FRAME_PIXELS(FP), .SD_BASE(BASE)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bl_write   (bl_write),
    .bl_read    (bl_read),
    .bl_addr    (bl_addr),
    .bl_wdata   (bl_wdata),
    .bl_rdata   (bl_rdata),
    .bl_grant   (bl_grant),
    .frame_ready(frame_ready),
    .m9_we      (m9_we),
    .m9_waddr   (m9_waddr),
    .m9_wdata   (m9_wdata),
    .m9_raddr   (m9_raddr),
    .m9_rdata   (m9_rdata),
    .sd         (sd_bus),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // M9 RAM model: synchronous write, registered read.
  logic [23:0] ram [0:15];
  always @(posedge clk) begin
    if (m9_we) ram[m9_waddr[3:0]] <= m9_wdata;
    m9_rdata <= ram[m9_raddr[3:0]];
  end

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int accepted = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [25:0] addr;
    logic [31:0] data;
  } sd_exp_t;
  sd_exp_t exp_q[$];
  logic [23:0] exp_ram [0:15];

  // Scoreboard: every accepted SDRAM write pops one expectation.
  always @(negedge clk) begin
    if (flush_done) done_cnt++;
    if (n_rst && sd_bus.sd_write && !sd_bus.sd_waitrequest) begin
      accepted++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sd_unexpected_write actual=%h required=none", sd_bus.sd_address);
      end else begin
        sd_exp_t e;
        e = exp_q.pop_front();
        check("sd_address", 32'(sd_bus.sd_address), 32'(e.addr));
        check("sd_wdata", sd_bus.sd_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int n = 0; n < FP; n++)
      exp_q.push_back('{addr: BASE + 26'(4 * n), data: {8'h00, exp_ram[n]}});
  endtask

  task automatic start_flush();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  // Counts cycles from the frame_ready cycle (0) to the flush_done cycle.
  task automatic run_to_done(output int cyc);
    cyc = 1;
    while (!flush_done && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_sd_addr(input logic [25:0] a, output int found);
    int k;
    k = 0;
    while (!(sd_bus.sd_write && sd_bus.sd_address == a) && k < 60) begin
      tick();
      k++;
    end
    found = (k < 60) ? 1 : 0;
  endtask

  typedef struct {
    logic        we;
    logic        rd;
    logic [16:0] addr;
    logic [23:0] wdata;
    logic [23:0] exp_rd;
  } blend_vec_t;

  blend_vec_t vecs [0:8];

  initial begin
    int cyc;
    int found;
    int d0;

    vecs[0] = '{we: 1'b1, rd: 1'b0, addr: 17'd5, wdata: 24'hFF8040, exp_rd: 24'h0};
    vecs[1] = '{we: 1'b0, rd: 1'b1, addr: 17'd5, wdata: 24'h0, exp_rd: 24'hFF8040};
    vecs[2] = '{we: 1'b1, rd: 1'b0, addr: 17'd0, wdata: 24'h0A0B0C, exp_rd: 24'h0};
    vecs[3] = '{we: 1'b1, rd: 1'b0, addr: 17'd1, wdata: 24'h1A1B1C, exp_rd: 24'h0};
    vecs[4] = '{we: 1'b1, rd: 1'b0, addr: 17'd2, wdata: 24'h2A2B2C, exp_rd: 24'h0};
    vecs[5] = '{we: 1'b1, rd: 1'b0, addr: 17'd3, wdata: 24'h3A3B3C, exp_rd: 24'h0};
    vecs[6] = '{we: 1'b0, rd: 1'b1, addr: 17'd2, wdata: 24'h0, exp_rd: 24'h2A2B2C};
    vecs[7] = '{we: 1'b0, rd: 1'b1, addr: 17'd0, wdata: 24'h0, exp_rd: 24'h0A0B0C};
    vecs[8] = '{we: 1'b0, rd: 1'b1, addr: 17'd3, wdata: 24'h0, exp_rd: 24'h3A3B3C};

    for (int i = 0; i < 16; i++) begin
      ram[i] = '0;
      exp_ram[i] = '0;
    end
    sd_bus.sd_waitrequest = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_sd_write", 32'(sd_bus.sd_write), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_flush_done", 32'(flush_done), 0);
    check("rst_bl_grant", 32'(bl_grant), 1);
    n_rst = 1'b1;
    tick();

    // Blend access table
    for (int i = 0; i < 9; i++) begin
      bl_write = vecs[i].we;
      bl_read  = vecs[i].rd;
      bl_addr  = vecs[i].addr;
      bl_wdata = vecs[i].wdata;
      if (vecs[i].we) exp_ram[vecs[i].addr[3:0]] = vecs[i].wdata;
      #1;
      check("blend_grant", 32'(bl_grant), 1);
      check("blend_m9_we", 32'(m9_we), 32'(vecs[i].we));
      check("blend_m9_raddr", 32'(m9_raddr), 32'(vecs[i].addr));
      if (vecs[i].we) begin
        check("blend_m9_waddr", 32'(m9_waddr), 32'(vecs[i].addr));
        check("blend_m9_wdata", 32'(m9_wdata), 32'(vecs[i].wdata));
      end
      tick();
      if (vecs[i].rd) check("blend_rdata", 32'(bl_rdata), 32'(vecs[i].exp_rd));
    end
    bl_write = 1'b0;
    bl_read  = 1'b0;

    // Flush 1: bl_write alongside frame_ready is still performed
    bl_write = 1'b1;
    bl_addr  = 17'd9;
    bl_wdata = 24'h123456;
    exp_ram[9] = 24'h123456;
    #1;
    check("fr_cycle_m9_we", 32'(m9_we), 1);
    push_frame();
    start_flush();
    bl_write = 1'b0;
    check("flush_busy", 32'(busy), 1);
    check("flush_grant", 32'(bl_grant), 0);
    run_to_done(cyc);
    check("flush1_cycles", cyc, 3 * FP + 1);
    tick();
    check("flush1_done_pulse", 32'(flush_done), 0);
    check("flush1_busy_after", 32'(busy), 0);
    check("flush1_done_cnt", done_cnt, 1);
    check("flush1_queue_empty", exp_q.size(), 0);
    bl_read = 1'b1;
    bl_addr = 17'd9;
    tick();
    check("fr_cycle_write_rdata", 32'(bl_rdata), 32'h123456);
    bl_read = 1'b0;

    // Flush 2: blocked blender requests, second frame_ready, stall on pixel 2
    push_frame();
    start_flush();
    bl_write = 1'b1;
    bl_addr  = 17'd3;
    bl_wdata = 24'hDEAD00;
    frame_ready = 1'b1;
    #1;
    check("block_m9_we", 32'(m9_we), 0);
    check("block_grant", 32'(bl_grant), 0);
    tick();
    bl_write = 1'b0;
    frame_ready = 1'b0;
    wait_sd_addr(BASE + 26'h8, found);
    check("stall_reach_pix2", found, 1);
    sd_bus.sd_waitrequest = 1'b1;
    d0 = accepted;
    for (int i = 0; i < 5; i++) begin
      check("stall_sd_write", 32'(sd_bus.sd_write), 1);
      check("stall_sd_address", 32'(sd_bus.sd_address), 32'(BASE + 26'h8));
      check("stall_sd_wdata", sd_bus.sd_wdata, {8'h00, exp_ram[2]});
      tick();
    end
    check("stall_no_accept", accepted - d0, 0);
    sd_bus.sd_waitrequest = 1'b0;
    run_to_done(cyc);
    check("flush2_done_seen", 32'(flush_done), 1);
    for (int i = 0; i < 20; i++) tick();
    check("flush2_done_cnt", done_cnt, 2);
    check("flush2_busy_idle", 32'(busy), 0);
    check("flush2_queue_empty", exp_q.size(), 0);

    // Flush 3: reset in FL_WRITE of pixel 1, then restart from pixel 0
    push_frame();
    start_flush();
    wait_sd_addr(BASE + 26'h4, found);
    check("rst_reach_pix1", found, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_sd_write", 32'(sd_bus.sd_write), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_grant", 32'(bl_grant), 1);
    exp_q.delete();
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("rst_no_done", done_cnt, 2);
    push_frame();
    start_flush();
    run_to_done(cyc);
    check("flush3_cycles", cyc, 3 * FP + 1);
    tick();
    check("flush3_done_cnt", done_cnt, 3);
    check("flush3_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
